me_result_deser: RTL and testbench
==================================

Name: me_result_deser

Overview:
- Consumes the bit-serial result stream of the me266 motion-estimation core (sign_sad, sad_out, x_out, y_out).
- Reassembles each serial frame into a parallel SAD and motion-vector result and decodes the vector.
- Buffers results in a small FIFO and presents them downstream over a valid/ready handshake.
- Sits directly downstream of me266, feeding the frame-level result writer / MV store.

Parameters:
- SAD_W, 14, SAD width in bits; also the frame length in strobe cycles.
- MV_W, 4, serial motion-vector component width (must be less than SAD_W).
- FIFO_DEPTH, 2, result FIFO entries (power of 2, at least 2).
- ACC_W, 32, SAD accumulator width (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sign_sad  in  1  serial frame strobe from me266
- sad_out  in  1  SAD serial bit, MSB first
- x_out  in  1  MV x serial bit, MSB first
- y_out  in  1  MV y serial bit, MSB first
- res_ready  in  1  downstream ready
- res_valid  out  1  FIFO head valid
- res_sad  out  SAD_W  unsigned SAD
- res_mvx  out  MV_W+1  signed decoded x
- res_mvy  out  MV_W+1  signed decoded y
- res_idx  out  16  block index of the head result
- frame_err  out  1  one-cycle pulse on a truncated frame
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- fifo_cnt  out  clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Frame format:
  - sign_sad is high for exactly SAD_W consecutive cycles per frame.
  - sad_out carries one bit per strobe cycle, MSB first.
  - x_out/y_out are valid on strobe cycles 0..MV_W-1, MSB first; their values on later strobe cycles are ignored.
- Capture:
  - Counter bit_cnt (0..SAD_W-1) increments on each strobe cycle.
  - SAD shift register shifts left with sad_out inserted at the LSB.
  - MV shift registers shift only while bit_cnt < MV_W.
- Completion:
  - On the edge capturing bit SAD_W-1, the full word ({sad_sh[SAD_W-2:0], sad_out}) is pushed, bit_cnt returns to 0, and the block counter increments.
  - res_valid rises in the next cycle when the FIFO was empty (latency 1 after the last strobe cycle).
- Back-to-back frames: sign_sad held high across the boundary starts a new frame immediately, with no gap required.
- Truncation:
  - sign_sad low while bit_cnt is in 1..SAD_W-1 discards the partial frame and pulses frame_err high for 1 cycle.
  - bit_cnt returns to 0; the block counter does not increment.
- MV decode:
  - Code 1000 (binary) decodes to +8 (5-bit 01000).
  - All other codes are two's complement, sign-extended to MV_W+1 bits (range -7..+8).
- res_idx:
  - Holds the block-counter value at push time; it starts at 0 and wraps at 16 bits.
  - Dropped frames still consume an index, so gaps in res_idx reveal drops.
- FIFO:
  - A pop occurs when res_valid and res_ready are both high.
  - A push on completion is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the result is dropped and overflow is set until reset.
  - Simultaneous push and pop leaves fifo_cnt unchanged.
  - Head outputs are stable while res_valid is high and res_ready is low.
  - Outputs read 0 when the FIFO is empty.
- Reset:
  - All outputs go to 0 and the FIFO empties; bit_cnt, the block counter and overflow clear.
  - A partial frame in progress is discarded without frame_err.
  - Strobe bits sampled during the reset cycle are ignored.

Optional Feature:
- Macro: ME_SAD_ACC_EN.
- When defined:
  - Adds input acc_clr (1 bit) and output sad_acc (ACC_W bits).
  - sad_acc adds every completed frame's SAD, including dropped frames, and saturates at all-ones.
  - acc_clr zeroes the accumulator; if a frame completes in the same cycle, sad_acc loads that frame's SAD.
  - sad_acc resets to 0.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single frame: SAD=5000 (01001110001000), x=1101, y=1000, res_ready=1.
  - res_valid rises 1 cycle after the 14th strobe cycle.
  - res_sad=5000, res_mvx=-3, res_mvy=+8, res_idx=0, single-cycle pulse.
- Truncation: strobe for 7 cycles, then low.
  - frame_err pulses 1 cycle, no res_valid.
  - A following good frame gets res_idx=0.
- Backpressure: res_ready=0, three frames with SAD 10/20/30.
  - fifo_cnt=2, overflow=1.
  - Raising res_ready then yields SAD 10 (idx 0) then 20 (idx 1), then empty.
- Back-to-back: strobe held high for 28 cycles carrying SAD 16383 then 0, with x=0111 then 1001.
  - Two results: (16383, +7) then (0, -7), idx 0 and 1, no frame_err.
- Reset mid-frame: rst asserted at strobe bit 6.
  - No result and no frame_err.
  - All outputs 0; the next frame completes normally with idx 0.
- With ME_SAD_ACC_EN:
  - Frames of SAD 100 and 200 give sad_acc=300.
  - acc_clr coinciding with a completing frame of SAD 50 gives sad_acc=50.
  - A preloaded near-max value saturates to all-ones.

Source files
------------

// File: rtl/me_result_deser.sv
// me_result_deser
//   Reassembles the bit-serial result frames of the me266 motion-estimation
//   core into parallel SAD + motion-vector results. It decodes the vectors and
//   queues the results in a small FIFO with a valid/ready output.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   sign_sad          frame strobe, high for SAD_W consecutive cycles per frame
//   sad_out           SAD serial bit, MSB first
//   x_out, y_out      MV serial bits, MSB first, valid on strobe cycles 0..MV_W-1
//   res_ready         downstream ready
//   res_valid         FIFO head valid
//   res_sad/mvx/mvy   head result (mvx/mvy are two's complement, MV_W+1 bits)
//   res_idx           block index of the head result
//   frame_err         one-cycle pulse on a truncated frame
//   overflow          sticky, set when a result is dropped on a full FIFO
//   fifo_cnt          FIFO occupancy
//
// Optional feature (macro ME_SAD_ACC_EN)
//   acc_clr           input, clears the SAD accumulator
//   sad_acc           output, saturating sum of every completed frame's SAD
module me_result_deser #(
  parameter int SAD_W      = 14,
  parameter int MV_W       = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ACC_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sign_sad,
  input  logic                            sad_out,
  input  logic                            x_out,
  input  logic                            y_out,
  input  logic                            res_ready,
  output logic                            res_valid,
  output logic [SAD_W-1:0]                res_sad,
  output logic [MV_W:0]                   res_mvx,
  output logic [MV_W:0]                   res_mvy,
  output logic [15:0]                     res_idx,
  output logic                            frame_err,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt
`ifdef ME_SAD_ACC_EN
  ,
  input  logic                            acc_clr,
  output logic [ACC_W-1:0]                sad_acc
`endif
);

  localparam int BC_W = $clog2(SAD_W);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(SAD_W - 1);
  localparam logic [BC_W-1:0] MV_LIM   = BC_W'(MV_W);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [MV_W:0]    mvx;
    logic [MV_W:0]    mvy;
    logic [15:0]      idx;
  } res_t;

  // The single code 100..0 means +2^(MV_W-1) rather than the most negative value.
  function automatic logic [MV_W:0] mv_dec(input logic [MV_W-1:0] c);
    if (c == {1'b1, {(MV_W-1){1'b0}}}) mv_dec = {1'b0, c};
    else                               mv_dec = {c[MV_W-1], c};
  endfunction

  // ---------------- serial capture ----------------
  logic [BC_W-1:0]  bit_cnt;
  logic [SAD_W-2:0] sad_sh;
  logic [MV_W-1:0]  mvx_sh, mvy_sh;
  logic [15:0]      blk_cnt;
  logic [SAD_W-1:0] sad_word;
  logic             last;

  assign sad_word = {sad_sh, sad_out};
  assign last     = sign_sad && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      blk_cnt   <= '0;
      frame_err <= 1'b0;
      sad_sh    <= '0;
      mvx_sh    <= '0;
      mvy_sh    <= '0;
    end else begin
      // Strobe dropping mid-frame: discard the partial frame.
      frame_err <= !sign_sad && (bit_cnt != '0);
      if (sign_sad) begin
        sad_sh <= sad_word[SAD_W-2:0];
        if (bit_cnt < MV_LIM) begin
          mvx_sh <= {mvx_sh[MV_W-2:0], x_out};
          mvy_sh <= {mvy_sh[MV_W-2:0], y_out};
        end
        if (last) begin
          bit_cnt <= '0;
          blk_cnt <= blk_cnt + 16'd1;  // dropped frames consume an index too
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        bit_cnt <= '0;
      end
    end
  end

  // ---------------- result FIFO ----------------
  res_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            pop, push_ok;
  res_t            wr_ent, head;

  assign pop     = res_valid && res_ready;
  assign push_ok = last && ((cnt != FULL_CNT) || pop);  // a same-cycle pop frees a slot
  assign wr_ent  = '{sad: sad_word, mvx: mv_dec(mvx_sh), mvy: mv_dec(mvy_sh), idx: blk_cnt};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (last && !push_ok) overflow <= 1'b1;
    end
  end

  // Head outputs are forced to zero while the FIFO is empty.
  assign head      = mem[rd_ptr];
  assign res_valid = (cnt != '0);
  assign res_sad   = res_valid ? head.sad : '0;
  assign res_mvx   = res_valid ? head.mvx : '0;
  assign res_mvy   = res_valid ? head.mvy : '0;
  assign res_idx   = res_valid ? head.idx : '0;
  assign fifo_cnt  = cnt;

`ifdef ME_SAD_ACC_EN
  // ---------------- saturating SAD accumulator ----------------
  logic [ACC_W:0] acc_sum;
  assign acc_sum = {1'b0, sad_acc} + (ACC_W+1)'(sad_word);

  always_ff @(posedge clk) begin
    if (rst)          sad_acc <= '0;
    else if (acc_clr) sad_acc <= last ? ACC_W'(sad_word) : '0;
    else if (last)    sad_acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  end
`endif

endmodule

// File: tb/tb_me_result_deser.sv
module tb_me_result_deser;
  localparam int SW = 14;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst, sign_sad, sad_out, x_out, y_out, res_ready;
  logic          res_valid, frame_err, overflow;
  logic [SW-1:0] res_sad;
  logic [MW:0]   res_mvx, res_mvy;
  logic [15:0]   res_idx;
  logic [1:0]    fifo_cnt;
`ifdef ME_SAD_ACC_EN
  logic          acc_clr;
  logic [15:0]   sad_acc;
  logic          clr_next;
`endif

  int checks = 0, errors = 0, err_seen = 0, e0;

  me_result_deser #(.SAD_W(SW), .MV_W(MW), .FIFO_DEPTH(2), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .sign_sad(sign_sad), .sad_out(sad_out),
    .x_out(x_out), .y_out(y_out), .res_ready(res_ready),
    .res_valid(res_valid), .res_sad(res_sad), .res_mvx(res_mvx),
    .res_mvy(res_mvy), .res_idx(res_idx), .frame_err(frame_err),
    .overflow(overflow), .fifo_cnt(fifo_cnt)
`ifdef ME_SAD_ACC_EN
    , .acc_clr(acc_clr), .sad_acc(sad_acc)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive n strobe cycles of a frame; MV lines carry junk (1) after bit MW-1.
  task automatic bits(input logic [SW-1:0] sad, input logic [MW-1:0] x,
                      input logic [MW-1:0] y, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sign_sad = 1'b1;
      sad_out  = sad[SW-1-i];
      x_out    = (i < MW) ? x[MW-1-i] : 1'b1;
      y_out    = (i < MW) ? y[MW-1-i] : 1'b1;
`ifdef ME_SAD_ACC_EN
      acc_clr  = clr_next && (i == n-1);
`endif
    end
  endtask

  task automatic frame(input logic [SW-1:0] sad, input logic [MW-1:0] x, input logic [MW-1:0] y);
    bits(sad, x, y, SW);
  endtask

  task automatic gap();
    @(negedge clk);
    sign_sad = 1'b0; sad_out = 1'b0; x_out = 1'b0; y_out = 1'b0;
`ifdef ME_SAD_ACC_EN
    acc_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sign_sad = 1'b0; sad_out = 1'b0; x_out = 1'b0; y_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sign_sad = 0; sad_out = 0; x_out = 0; y_out = 0; res_ready = 0;
`ifdef ME_SAD_ACC_EN
    acc_clr = 0; clr_next = 0;
`endif
    // ---- reset state ----
    do_reset();
    chk("rst_valid", res_valid, 0);
    chk("rst_sad", res_sad, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);

    // ---- single frame ----
    res_ready = 1'b1;
    frame(14'd5000, 4'b1101, 4'b1000);
    gap();
    chk("s1_valid", res_valid, 1);
    chk("s1_sad", res_sad, 5000);
    chk("s1_mvx", res_mvx, 5'b11101);
    chk("s1_mvy", res_mvy, 5'b01000);
    chk("s1_idx", res_idx, 0);
    @(negedge clk);
    chk("s1_pulse", res_valid, 0);
    chk("s1_empty_sad", res_sad, 0);

    // ---- truncation ----
    do_reset();
    bits(14'd1234, 4'b0001, 4'b1111, 7);
    gap();
    @(negedge clk);
    chk("tr_ferr", frame_err, 1);
    chk("tr_novalid", res_valid, 0);
    @(negedge clk);
    chk("tr_ferr_off", frame_err, 0);
    frame(14'd1234, 4'b0001, 4'b1111);
    gap();
    chk("tr_valid", res_valid, 1);
    chk("tr_sad", res_sad, 1234);
    chk("tr_mvx", res_mvx, 5'b00001);
    chk("tr_mvy", res_mvy, 5'b11111);
    chk("tr_idx", res_idx, 0);

    // ---- backpressure / overflow ----
    do_reset();
    res_ready = 1'b0;
    frame(14'd10, 4'b0000, 4'b0000); gap();
    frame(14'd20, 4'b0000, 4'b0000); gap();
    frame(14'd30, 4'b0000, 4'b0000); gap();
    chk("bp_cnt", fifo_cnt, 2);
    chk("bp_ovf", overflow, 1);
    chk("bp_sad0", res_sad, 10);
    @(negedge clk);
    chk("bp_stable", res_sad, 10);
    res_ready = 1'b1;
    chk("bp_idx0", res_idx, 0);
    @(negedge clk);
    chk("bp_sad1", res_sad, 20);
    chk("bp_idx1", res_idx, 1);
    chk("bp_cnt1", fifo_cnt, 1);
    @(negedge clk);
    chk("bp_empty", res_valid, 0);
    chk("bp_cnt0", fifo_cnt, 0);
    chk("bp_ovf_sticky", overflow, 1);

    // ---- back-to-back ----
    do_reset();
    e0 = err_seen;
    res_ready = 1'b0;
    frame(14'd16383, 4'b0111, 4'b0000);
    frame(14'd0, 4'b1001, 4'b0000);
    gap();
    chk("bb_cnt", fifo_cnt, 2);
    chk("bb_sad0", res_sad, 16383);
    chk("bb_mvx0", res_mvx, 5'b00111);
    chk("bb_idx0", res_idx, 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bb_valid1", res_valid, 1);
    chk("bb_sad1", res_sad, 0);
    chk("bb_mvx1", res_mvx, 5'b11001);
    chk("bb_idx1", res_idx, 1);
    @(negedge clk); #1;
    chk("bb_noferr", err_seen - e0, 0);

    // ---- reset mid-frame ----
    do_reset();
    e0 = err_seen;
    bits(14'h3FFF, 4'b0101, 4'b0101, 6);
    @(negedge clk);
    rst = 1'b1; sign_sad = 1'b1; sad_out = 1'b1;
    @(negedge clk);
    rst = 1'b0; sign_sad = 1'b0; sad_out = 1'b0;
    chk("rm_valid", res_valid, 0);
    chk("rm_sad", res_sad, 0);
    chk("rm_cnt", fifo_cnt, 0);
    chk("rm_ferr", frame_err, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rm_noferr", err_seen - e0, 0);
    chk("rm_noresult", res_valid, 0);
    frame(14'd777, 4'b0010, 4'b1110);
    gap();
    chk("rm_sad_next", res_sad, 777);
    chk("rm_mvx_next", res_mvx, 5'b00010);
    chk("rm_mvy_next", res_mvy, 5'b11110);
    chk("rm_idx_next", res_idx, 0);

`ifdef ME_SAD_ACC_EN
    // ---- accumulator ----
    do_reset();
    chk("acc_rst", sad_acc, 0);
    frame(14'd100, 4'b0000, 4'b0000); gap();
    frame(14'd200, 4'b0000, 4'b0000); gap();
    chk("acc_sum", sad_acc, 300);
    clr_next = 1'b1;
    frame(14'd50, 4'b0000, 4'b0000);
    clr_next = 1'b0;
    gap();
    chk("acc_clr_load", sad_acc, 50);
    clr_next = 1'b1;
    frame(14'd16383, 4'b0000, 4'b0000);
    clr_next = 1'b0;
    frame(14'd16383, 4'b0000, 4'b0000);
    frame(14'd16383, 4'b0000, 4'b0000);
    frame(14'd16383, 4'b0000, 4'b0000);
    gap();
    chk("acc_preload", sad_acc, 65532);
    frame(14'd16383, 4'b0000, 4'b0000); gap();
    chk("acc_sat", sad_acc, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
